// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and constants for the sweep-and-capture controller.
//   - sweep_state_e : controller state encoding (also exported on state_dbg)
//   - sample pack layout: {dac[11:0], 4'd0, adc[11:0], 4'd0}
//   - default sweep range and settle interval
package sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_STEP    = 3'd4
    } sweep_state_e;

    localparam int SAMPLE_W = 12;
    localparam int PAD_W    = 4;
    localparam int ADC_LSB  = PAD_W;
    localparam int DAC_LSB  = ADC_LSB + SAMPLE_W + PAD_W;

    localparam int DEF_PHI_START     = 20;
    localparam int DEF_PHI_STOP      = 410;
    localparam int DEF_SETTLE_CYCLES = 300000;

    // Packs one DAC/ADC pair into a RAM word; pad nibbles are zero.
    function automatic logic [31:0] pack_sample(input logic [SAMPLE_W-1:0] dac,
                                                input logic [SAMPLE_W-1:0] adc);
        logic [31:0] w;
        w = '0;
        w[DAC_LSB +: SAMPLE_W] = dac;
        w[ADC_LSB +: SAMPLE_W] = adc;
        return w;
    endfunction

endpackage

// File: rtl/sweep_timer.sv
// sweep_timer: loadable down-counter with terminal-count flag.
// Shared by the settle wait and the capture frame length.
// Ports:
//   clk_50M, reset : clock, asynchronous active-high reset
//   load, load_val : load count with load_val (has priority over en)
//   en             : decrement by one, holds at zero
//   tc             : count is zero
module sweep_timer #(
    parameter int W = 8
) (
    input  logic         clk_50M,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sweep_capture.sv
// sweep_capture: steps the NCO phase increment from PHI_START to PHI_STOP,
// waits SETTLE_CYCLES after each change, writes DEPTH packed {DAC, ADC}
// samples to the RAM write port, then hands the frame to the UDP sender.
//
// Optional build macro: SWEEP_AUTO_RESTART_EN -- when defined, the sweep
// restarts at PHI_START after the last frame instead of returning to IDLE.
//
// Ports:
//   clk_50M, reset          : clock, asynchronous active-high reset
//   start                   : one-cycle pulse, (re)starts a sweep (aborts any frame)
//   dac_sample, adc_sample  : 12-bit signed samples, registered into ram_wdata
//   phi_inc                 : NCO phase increment
//   ram_wren/wraddr/wdata   : RAM write port
//   send_req, send_ack      : frame handoff to UDP sender
//   busy                    : not in IDLE
//   sweep_done              : one-cycle pulse once the last frame is acknowledged
//   state_dbg               : current controller state
//
// Frame handoff: send_req rises once the last sample of a frame is written
// and stays high until send_ack is sampled high on a clock edge; the frame
// is transferred on that edge and send_req drops the next cycle. send_ack
// outside SEND has no effect, and start on the same edge overrides it.
module sweep_capture
    import sweep_pkg::*;
#(
    parameter int DEPTH         = 4096,
    parameter int ADDR_W        = 12,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int PHI_W         = 11,
    parameter int PHI_START     = DEF_PHI_START,
    parameter int PHI_STOP      = DEF_PHI_STOP,
    parameter int PHI_STEP      = 1
) (
    input  logic               clk_50M,
    input  logic               reset,
    input  logic               start,
    input  logic [11:0]        dac_sample,
    input  logic [11:0]        adc_sample,
    output logic [PHI_W-1:0]   phi_inc,
    output logic               ram_wren,
    output logic [ADDR_W-1:0]  ram_wraddr,
    output logic [31:0]        ram_wdata,
    output logic               send_req,
    input  logic               send_ack,
    output logic               busy,
    output logic               sweep_done,
    output sweep_state_e       state_dbg
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DEPTH) ? SETTLE_CYCLES : DEPTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAPTURE_LOAD = CNT_W'(DEPTH - 1);

    sweep_state_e     state;
    logic             timer_load;
    logic             timer_en;
    logic [CNT_W-1:0] timer_val;
    logic             timer_tc;
    logic [PHI_W:0]   phi_next;
    logic             phi_over;

    // One extra bit so the end-of-range test cannot be fooled by wrap-around.
    assign phi_next = {1'b0, phi_inc} + (PHI_W + 1)'(PHI_STEP);
    assign phi_over = phi_next > (PHI_W + 1)'(PHI_STOP);

    // The timer is loaded with N-1 on entry so that tc marks the N-th cycle
    // of the settle wait and the last write of the frame.
    always_comb begin
        timer_load = 1'b0;
        timer_en   = 1'b0;
        timer_val  = SETTLE_LOAD;
        if (start) begin
            timer_load = 1'b1;
        end else begin
            case (state)
                S_SETTLE: begin
                    if (timer_tc) begin
                        timer_load = 1'b1;
                        timer_val  = CAPTURE_LOAD;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                S_CAPTURE: timer_en   = 1'b1;
                S_STEP:    timer_load = 1'b1;
                default:   ;
            endcase
        end
    end

    sweep_timer #(.W(CNT_W)) u_timer (
        .clk_50M  (clk_50M),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            phi_inc    <= PHI_W'(PHI_START);
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
            ram_wdata  <= '0;
            send_req   <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (start) begin
                // Start from any state (re)begins the sweep; pending frame dropped.
                state      <= S_SETTLE;
                phi_inc    <= PHI_W'(PHI_START);
                ram_wren   <= 1'b0;
                ram_wraddr <= '0;
                send_req   <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    S_SETTLE: begin
                        if (timer_tc) begin
                            state      <= S_CAPTURE;
                            ram_wren   <= 1'b1;
                            ram_wraddr <= '0;
                            ram_wdata  <= pack_sample(dac_sample, adc_sample);
                        end
                    end
                    S_CAPTURE: begin
                        if (timer_tc) begin
                            state    <= S_SEND;
                            ram_wren <= 1'b0;
                            send_req <= 1'b1;
                        end else begin
                            ram_wraddr <= ram_wraddr + ADDR_W'(1);
                            ram_wdata  <= pack_sample(dac_sample, adc_sample);
                        end
                    end
                    S_SEND: begin
                        if (send_ack) begin
                            state    <= S_STEP;
                            send_req <= 1'b0;
                        end
                    end
                    S_STEP: begin
                        if (phi_over) begin
                            sweep_done <= 1'b1;
`ifdef SWEEP_AUTO_RESTART_EN
                            phi_inc    <= PHI_W'(PHI_START);
                            state      <= S_SETTLE;
`else
                            state      <= S_IDLE;
                            busy       <= 1'b0;
`endif
                        end else begin
                            phi_inc <= phi_next[PHI_W-1:0];
                            state   <= S_SETTLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_sweep_capture.sv
// Bench for sweep_capture with a small configuration (DEPTH=8,
// SETTLE_CYCLES=5, phase 20..22). The reference model tracks the sweep as
// a timeline: the cycle of the first write of the current frame, the cycle
// the frame was acknowledged, and the phase increment, all derived from
// the documented cycle timing.
module tb_sweep_capture;
    localparam int DEPTH     = 8;
    localparam int ADDR_W    = 3;
    localparam int SETTLE    = 5;
    localparam int PHI_W     = 11;
    localparam int PHI_START = 20;
    localparam int PHI_STOP  = 22;
    localparam int PHI_STEP  = 1;

    logic              clk_50M = 1'b0;
    logic              reset;
    logic              start;
    logic [11:0]       dac_sample;
    logic [11:0]       adc_sample;
    logic [PHI_W-1:0]  phi_inc;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [31:0]       ram_wdata;
    logic              send_req;
    logic              send_ack;
    logic              busy;
    logic              sweep_done;
    sweep_pkg::sweep_state_e state_dbg;

    sweep_capture #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE), .PHI_W(PHI_W),
        .PHI_START(PHI_START), .PHI_STOP(PHI_STOP), .PHI_STEP(PHI_STEP)
    ) dut (
        .clk_50M(clk_50M), .reset(reset), .start(start),
        .dac_sample(dac_sample), .adc_sample(adc_sample),
        .phi_inc(phi_inc), .ram_wren(ram_wren), .ram_wraddr(ram_wraddr),
        .ram_wdata(ram_wdata), .send_req(send_req), .send_ack(send_ack),
        .busy(busy), .sweep_done(sweep_done), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_50M = ~clk_50M;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    bit m_active, m_busy;
    int m_phi, m_fs, m_ack, m_delay, m_pend_cyc, m_pend_kind, m_done_cyc;
    int ack_lo = 0, ack_hi = 4;
    bit const_pat = 0, ack_spam = 0, abort_armed = 0;
    int obs_writes = 0, obs_done = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_ref(input logic [11:0] d, input logic [11:0] a);
        return {d, 4'h0, a, 4'h0};
    endfunction

    task automatic model_reset();
        m_active = 0; m_busy = 0; m_phi = PHI_START;
        m_fs = 0; m_ack = -1; m_pend_cyc = -1; m_done_cyc = -1; m_delay = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_values();
        check_val("rst_phi",   32'(phi_inc),    32'(PHI_START));
        check_val("rst_wren",  32'(ram_wren),   32'd0);
        check_val("rst_addr",  32'(ram_wraddr), 32'd0);
        check_val("rst_wdata", ram_wdata,       32'd0);
        check_val("rst_req",   32'(send_req),   32'd0);
        check_val("rst_busy",  32'(busy),       32'd0);
        check_val("rst_done",  32'(sweep_done), 32'd0);
    endtask

    // Compare the outputs of cycle cyc with the timeline model.
    task automatic check_outputs();
        bit exp_wren, exp_req, exp_done;
        if (m_pend_cyc == cyc) begin
            case (m_pend_kind)
                0: begin m_phi += PHI_STEP; m_fs = cyc + SETTLE; m_ack = -1;
                         m_delay = $urandom_range(ack_hi, ack_lo); end
                1: begin m_active = 0; m_busy = 0; end
                default: begin m_phi = PHI_START; m_fs = cyc + SETTLE; m_ack = -1;
                         m_delay = $urandom_range(ack_hi, ack_lo); end
            endcase
            m_pend_cyc = -1;
        end
        exp_wren = m_active && (cyc >= m_fs) && (cyc < m_fs + DEPTH);
        exp_req  = m_active && (cyc >= m_fs + DEPTH) && ((m_ack < 0) || (cyc <= m_ack));
        exp_done = (cyc == m_done_cyc);
        check_val("busy",       32'(busy),       32'(m_busy));
        check_val("wren",       32'(ram_wren),   32'(exp_wren));
        check_val("send_req",   32'(send_req),   32'(exp_req));
        check_val("sweep_done", 32'(sweep_done), 32'(exp_done));
        check_val("phi_inc",    32'(phi_inc),    32'(m_phi));
        if (sweep_done) obs_done++;
        if (ram_wren) begin
            obs_writes++;
            check_val("wraddr", 32'(ram_wraddr), 32'(cyc - m_fs));
            if (exp_q.size() == 0) check_val("wdata_queue_empty", 32'd0, 32'd1);
            else check_val("wdata", ram_wdata, exp_q.pop_front());
            if (const_pat) check_val("pack_7ff_800", ram_wdata, 32'h7FF0_8000);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_inputs(input bit st);
        logic [11:0] d, a;
        bit ack_v, req_now, do_start;
        do_start = st;
        if (abort_armed && m_active && (m_phi == PHI_START + PHI_STEP) && (cyc == m_fs + 3)) begin
            do_start = 1;
            abort_armed = 0;
        end
        if (const_pat) begin d = 12'h7FF; a = 12'h800; end
        else begin d = 12'($urandom); a = 12'($urandom); end
        req_now = m_active && (cyc >= m_fs + DEPTH) && (m_ack < 0);
        if (ack_spam) ack_v = 1;
        else if (req_now) ack_v = (cyc >= m_fs + DEPTH + m_delay);
        else ack_v = ($urandom_range(5, 0) == 0);
        if (do_start) begin
            if (req_now) ack_v = 1;   // start must win over a same-cycle ack
            m_active = 1; m_busy = 1; m_phi = PHI_START;
            m_fs = cyc + 1 + SETTLE; m_ack = -1; m_pend_cyc = -1; m_done_cyc = -1;
            m_delay = $urandom_range(ack_hi, ack_lo);
        end else if (req_now && ack_v) begin
            m_ack = cyc;
            m_pend_cyc = cyc + 2;
            if (m_phi + PHI_STEP > PHI_STOP) begin
                m_done_cyc = cyc + 2;
`ifdef SWEEP_AUTO_RESTART_EN
                m_pend_kind = 2;
`else
                m_pend_kind = 1;
`endif
            end else begin
                m_pend_kind = 0;
            end
        end
        // Data driven now lands in ram_wdata next cycle if that cycle writes.
        if (m_active && (cyc + 1 >= m_fs) && (cyc + 1 < m_fs + DEPTH))
            exp_q.push_back(pack_ref(d, a));
        start      = do_start;
        send_ack   = ack_v;
        dac_sample = d;
        adc_sample = a;
    endtask

    task automatic cycle(input bit st);
        @(posedge clk_50M);
        cyc++;
        @(negedge clk_50M);
        check_outputs();
        drive_inputs(st);
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!(m_done_cyc >= 0 && cyc > m_done_cyc) && n < budget) begin
            cycle(0);
            n++;
        end
        if (n >= budget) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset = 1; start = 0; send_ack = 0; dac_sample = '0; adc_sample = '0;
        model_reset();
        repeat (3) @(posedge clk_50M);
        @(negedge clk_50M);
        check_reset_values();
        reset = 0;
        cyc = 0;
        drive_inputs(0);
        repeat (5) cycle(0);

        // Full sweep with random data and short random ack delays.
        ack_lo = 0; ack_hi = 6; obs_writes = 0; obs_done = 0;
        cycle(1);
        run_until_done("sweep1", 400);
        check_val("sweep1_writes", 32'(obs_writes), 32'(3 * DEPTH));
        check_val("sweep1_done_pulses", 32'(obs_done), 32'd1);
        repeat (30) cycle(0);

        // Constant pattern and a 100-cycle ack delay on the first frame.
        const_pat = 1; ack_lo = 100; ack_hi = 100;
        cycle(1);
        n = 0;
        while (m_ack < 0 && n < 300) begin cycle(0); n++; end
        if (n >= 300) check_val("ack100_timeout", 32'd0, 32'd1);
        const_pat = 0; ack_lo = 0; ack_hi = 3;
        repeat (5) cycle(0);

        // Abort at address 3 of the second frame, then let the sweep finish.
        abort_armed = 1;
        cycle(1);
        run_until_done("abort", 600);
        check_val("abort_taken", 32'(abort_armed), 32'd0);
        repeat (10) cycle(0);

        // Reset while send_req is held; later acks must be ignored.
        ack_lo = 50; ack_hi = 50;
        cycle(1);
        n = 0;
        while (!(m_active && cyc >= m_fs + DEPTH + 3) && n < 100) begin cycle(0); n++; end
        if (n >= 100) check_val("send_wait_timeout", 32'd0, 32'd1);
        check_val("pre_reset_req", 32'(send_req), 32'd1);
        #3 reset = 1;
        #1 check_reset_values();
        model_reset();
        ack_spam = 1;
        repeat (3) cycle(0);
        reset = 0;
        repeat (12) cycle(0);
        ack_spam = 0;
        repeat (5) cycle(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
